// File: rtl/ahb_mem_responder.sv
// ahb_mem_responder: AHB-lite style word memory slave with
// programmable wait states and a two-cycle error response.
module ahb_mem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h0,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp
);

    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    localparam logic [3:0]  WS      = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DATA,
        ERR1
    } state_t;

    state_t state, state_nx;

    logic [31:0]   mem [DEPTH];
    logic [IW-1:0] idx_q;
    logic          wr_q;
    logic          err_q;
    logic [3:0]    wait_cnt;

    logic [31:0]   off;
    logic [IW-1:0] cap_idx;
    logic          cap;
    logic          cap_ok;
    logic          commit;
    logic          bypass;
    logic          unused_ok;

    assign off       = haddr - ADDR_BASE;
    assign cap_idx   = off[IW+1:2];
    assign unused_ok = ^off[1:0];
    assign cap       = hsel & hready;
    assign cap_ok    = (haddr[1:0] == 2'b00) &&
                       (haddr >= ADDR_BASE) &&
                       (off[31:2] < DEPTH_W);
    // a write retiring on the same edge a read of that word is captured
    assign commit    = (state == DATA) && wr_q && !err_q;
    assign bypass    = commit && (cap_idx == idx_q);

    // state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nx;
    end

    // next-state and handshake outputs
    always_comb begin
        state_nx = state;
        hready   = 1'b1;
        hresp    = 1'b0;
        unique case (state)
            IDLE, DATA: begin
                hresp = (state == DATA) && err_q;
                if (!cap)         state_nx = IDLE;
                else if (!cap_ok) state_nx = ERR1;
                else if (WS == 4'd0) state_nx = DATA;
                else              state_nx = WAIT;
            end
            WAIT: begin
                hready = 1'b0;
                if (wait_cnt == 4'd0) state_nx = DATA;
            end
            ERR1: begin
                hready   = 1'b0;
                hresp    = 1'b1;
                state_nx = DATA;
            end
            default: state_nx = IDLE;
        endcase
    end

    // address-phase capture, wait counter and registered read data
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idx_q    <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            wait_cnt <= 4'd0;
            hrdata   <= 32'h0;
        end else begin
            if (state == WAIT && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
            if (cap) begin
                idx_q    <= cap_idx;
                wr_q     <= hwrite;
                err_q    <= !cap_ok;
                wait_cnt <= (cap_ok && WS != 4'd0) ? WS - 4'd1 : 4'd0;
                if (!cap_ok)
                    hrdata <= 32'h0;
                else if (!hwrite)
                    hrdata <= bypass ? hwdata : mem[cap_idx];
            end
        end
    end

    // write port: commits on the closing edge of a good write data phase
    always_ff @(posedge clk) begin
        if (commit) mem[idx_q] <= hwdata;
    end

endmodule

// File: doc/ahb_mem_responder.md
AHB_MEM_RESPONDER -- requirements
Module: ahb_mem_responder

Interface
REQ-001 Parameters SHALL be as follows; each line gives name, default and meaning.
- ADDR_BASE, 0, byte address of word 0.
- DEPTH, 1024, number of 32-bit words.
- WAIT_STATES, 1, hready-low cycles inserted per transfer (0..15).
REQ-002 Ports SHALL be as follows; each line gives name, direction, width and meaning.
- clk, in, 1, single clock, rising edge.
- n_rst, in, 1, asynchronous active-low reset.
- hsel, in, 1, transfer-valid qualifier from the master.
- haddr, in, 32, byte address (address phase).
- hwrite, in, 1, 1 = write, 0 = read (address phase).
- hwdata, in, 32, write data (data phase).
- hrdata, out, 32, read data (data phase).
- hready, out, 1, 1 = data phase complete / ready for a new address.
- hresp, out, 1, 1 = error response.
REQ-003 The block SHALL use one clock, clk; reset SHALL be n_rst, asynchronous and active-low.

Function
REQ-004 Address phase: on a rising edge with hsel=1 and hready=1, the block SHALL capture haddr and hwrite.
REQ-005 A capture SHALL compute idx = (haddr - ADDR_BASE) >> 2.
REQ-006 The transfer SHALL be in range iff haddr[1:0]=0, haddr >= ADDR_BASE and idx < DEPTH.
REQ-007 The FSM SHALL have states IDLE, WAIT, DATA and ERR1.
REQ-008 IDLE SHALL drive hready=1 and hresp=0.
- Valid capture with WAIT_STATES>0 SHALL go to WAIT and load wait_cnt = WAIT_STATES-1.
- Valid capture with WAIT_STATES=0 SHALL go to DATA.
- Out-of-range capture SHALL go to ERR1.
REQ-009 WAIT SHALL drive hready=0 and hresp=0.
- wait_cnt SHALL decrement each cycle.
- At wait_cnt=0 the FSM SHALL go to DATA.
REQ-010 DATA SHALL drive hready=1 for exactly one cycle.
- Write: mem[idx] <= hwdata on the closing edge.
- Read: hrdata SHALL hold mem[idx] for the whole cycle.
- hsel=1 on that edge SHALL start a new address phase (back-to-back, no idle cycle).
- Otherwise the FSM SHALL go to IDLE.
REQ-011 Read data SHALL be registered into hrdata at the address-capture edge and held stable through WAIT and DATA.
REQ-012 ERR1 SHALL drive hready=0 and hresp=1 for one cycle, then go to DATA with hresp=1 (two-cycle AHB error response).
- Memory SHALL NOT be written.
- hrdata SHALL be 0.
REQ-013 hresp SHALL be 0 in every cycle not covered by REQ-012.
REQ-014 hsel=0 SHALL have no effect in IDLE, and SHALL be ignored in WAIT/ERR1 because hready=0 there.
REQ-015 Read-after-write to the same idx, back-to-back, SHALL return the newly written data.
REQ-016 Latency SHALL be as follows:
- Read data valid WAIT_STATES+1 cycles after the address-capture edge.
- Throughput one transfer per WAIT_STATES+1 cycles.
REQ-017 Memory contents SHALL be uninitialised and SHALL NOT be affected by reset.

Reset
REQ-018 While n_rst=0, outputs SHALL be hready=1, hresp=0 and hrdata=0, with state IDLE and wait_cnt=0.
REQ-019 Reset asserted mid-transfer SHALL abort the transfer and SHALL NOT commit a pending write.
REQ-020 The first address phase SHALL be accepted on the first rising edge after n_rst deasserts.

Verification
REQ-021 WAIT_STATES=1: write 0xDEADBEEF to haddr 0x10, then read 0x10.
- hready SHALL be low 1 cycle per transfer.
- The read SHALL return 0xDEADBEEF.
- hresp SHALL stay 0.
REQ-022 WAIT_STATES=0: back-to-back writes to 0x0, 0x4, 0x8 (values 1, 2, 3), then reads of the same addresses.
- hready SHALL stay 1 throughout.
- The reads SHALL return 1, 2, 3 in consecutive cycles.
REQ-023 Read of haddr 0x1000 (idx=1024) and of haddr 0x2 (unaligned):
- Each SHALL give hready=0/hresp=1, then hready=1/hresp=1, with hrdata=0.
- Memory SHALL be unchanged.
REQ-024 WAIT_STATES=3: a read SHALL hold hready low 3 cycles with hrdata stable; hsel pulses during the wait SHALL be ignored.
REQ-025 Pulse n_rst low during the WAIT of a write of 0x55 to 0x20.
- Outputs SHALL reset immediately to hready=1, hresp=0, hrdata=0.
- A later read of 0x20 SHALL NOT return 0x55 (it was pre-loaded 0xAA and SHALL return 0xAA).
REQ-026 ADDR_BASE=0x30D40 (200000): a write to 0x30D40 SHALL land at idx 0; an access to 0x30D3C SHALL produce an error response.
